// File: rtl/alarm_led_blinker.sv
// Alarm LED blinker: Avalon-MM slave with programmable ON/OFF phase lengths.
// While alarm_in is high the LED toggles between ON_TIME lit cycles and
// OFF_TIME dark cycles; each new ON phase bumps a saturating blink counter.
module alarm_led_blinker #(
  parameter int CNT_W   = 24,
  parameter int DEF_ON  = 12500000,
  parameter int DEF_OFF = 12500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        alarm_in,
  output logic        led_out
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] counter, counter_next;
  logic [CNT_W-1:0] on_time, off_time, on_time_next, off_time_next;
  logic [CNT_W-1:0] on_load, off_load;
  logic             force_on, invert, force_on_next, invert_next;
  logic [15:0]      blink_cnt, blink_cnt_next;
  logic             wr_en, clear_cnt, enter_on, led_next;
  logic             wdata_unused;

  // Not every writedata bit is stored for every address.
  assign wdata_unused = ^writedata;

  // Register values as they will be after this edge; phase loads use these so
  // a write landing on the same edge as a load takes effect immediately.
  always_comb begin
    wr_en         = chipselect & ~write_n;
    on_time_next  = on_time;
    off_time_next = off_time;
    force_on_next = force_on;
    invert_next   = invert;
    clear_cnt     = 1'b0;
    if (wr_en) begin
      case (address)
        2'd0: on_time_next = writedata[CNT_W-1:0];
        2'd1: off_time_next = writedata[CNT_W-1:0];
        2'd2: begin
          force_on_next = writedata[0];
          invert_next   = writedata[1];
        end
        default: clear_cnt = writedata[0];
      endcase
    end
    on_load  = (on_time_next == '0) ? '0 : on_time_next - CNT_W'(1);
    off_load = (off_time_next == '0) ? '0 : off_time_next - CNT_W'(1);
  end

  // Phase FSM: next state, next counter value and ON-entry detection.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    enter_on     = 1'b0;
    case (state)
      IDLE: begin
        if (alarm_in) begin
          state_next   = ON;
          counter_next = on_load;
          enter_on     = 1'b1;
        end
      end
      ON: begin
        if (!alarm_in) begin
          state_next   = IDLE;
          counter_next = '0;
        end else if (counter == '0) begin
          state_next   = OFF;
          counter_next = off_load;
        end else begin
          counter_next = counter - CNT_W'(1);
        end
      end
      OFF: begin
        if (!alarm_in) begin
          state_next   = IDLE;
          counter_next = '0;
        end else if (counter == '0) begin
          state_next   = ON;
          counter_next = on_load;
          enter_on     = 1'b1;
        end else begin
          counter_next = counter - CNT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  // Blink counter update (clear beats increment) and LED drive for next cycle.
  always_comb begin
    blink_cnt_next = blink_cnt;
    if (clear_cnt) begin
      blink_cnt_next = '0;
    end else if (enter_on && blink_cnt != 16'hFFFF) begin
      blink_cnt_next = blink_cnt + 16'd1;
    end
    led_next = ((state_next == ON) | force_on_next) ^ invert_next;
  end

  // Combinational read mux, zero-extended to 32 bits.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = 32'(on_time);
      2'd1: readdata = 32'(off_time);
      2'd2: readdata = {30'd0, invert, force_on};
      default: readdata = {blink_cnt, 14'd0, state == ON, state != IDLE};
    endcase
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      counter   <= '0;
      on_time   <= CNT_W'(DEF_ON);
      off_time  <= CNT_W'(DEF_OFF);
      force_on  <= 1'b0;
      invert    <= 1'b0;
      blink_cnt <= '0;
      led_out   <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      on_time   <= on_time_next;
      off_time  <= off_time_next;
      force_on  <= force_on_next;
      invert    <= invert_next;
      blink_cnt <= blink_cnt_next;
      led_out   <= led_next;
    end
  end

endmodule

// File: tb/tb_alarm_led_blinker.sv
// Self-checking bench for alarm_led_blinker: directed scenarios plus a random
// run, all compared cycle by cycle against a phase/remaining-cycles model.
module tb_alarm_led_blinker;

  localparam int CNT_W   = 24;
  localparam int DEF_ON  = 12500000;
  localparam int DEF_OFF = 12500000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        alarm_in;
  logic        led_out;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 = dark/idle, 1 = lit phase, 2 = dark phase; left counts the
  // cycles still to be spent in the current phase, including the present one.
  int               m_phase;
  int               m_left;
  logic [CNT_W-1:0] m_on, m_off;
  logic             m_force, m_inv, m_led;
  logic [15:0]      m_blinks;

  alarm_led_blinker #(.CNT_W(CNT_W), .DEF_ON(DEF_ON), .DEF_OFF(DEF_OFF)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .alarm_in(alarm_in), .led_out(led_out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return 32'(m_on);
      2'd1: return 32'(m_off);
      2'd2: return {30'd0, m_inv, m_force};
      default: return {m_blinks, 14'd0, m_phase == 1, m_phase != 0};
    endcase
  endfunction

  task automatic model_edge();
    logic             wr, nf, ni, entered;
    logic [CNT_W-1:0] non, noff;
    int               eon, eoff;
    if (!reset_n) begin
      m_phase = 0; m_left = 0; m_on = CNT_W'(DEF_ON); m_off = CNT_W'(DEF_OFF);
      m_force = 0; m_inv = 0; m_blinks = 0; m_led = 0;
    end else begin
      wr   = chipselect && !write_n;
      non  = (wr && address == 2'd0) ? writedata[CNT_W-1:0] : m_on;
      noff = (wr && address == 2'd1) ? writedata[CNT_W-1:0] : m_off;
      nf   = (wr && address == 2'd2) ? writedata[0] : m_force;
      ni   = (wr && address == 2'd2) ? writedata[1] : m_inv;
      eon  = (non == 0) ? 1 : int'(non);
      eoff = (noff == 0) ? 1 : int'(noff);
      entered = 0;
      if (m_phase != 0 && !alarm_in) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (alarm_in) begin m_phase = 1; m_left = eon; entered = 1; end
      end else if (m_left > 1) begin
        m_left = m_left - 1;
      end else if (m_phase == 1) begin
        m_phase = 2; m_left = eoff;
      end else begin
        m_phase = 1; m_left = eon; entered = 1;
      end
      if (wr && address == 2'd3 && writedata[0]) m_blinks = 0;
      else if (entered && m_blinks != 16'hFFFF) m_blinks = m_blinks + 16'd1;
      m_on = non; m_off = noff; m_force = nf; m_inv = ni;
      m_led = ((m_phase == 1) || nf) ^ ni;
    end
  endtask

  task automatic tick();
    logic [31:0] exp_rd;
    model_edge();
    exp_rd = model_read(address);
    @(posedge clk);
    #1;
    total++;
    if (led_out !== m_led) begin
      bad++;
      $display("[TB] FAIL led_out: got %b expected %b at %0t", led_out, m_led, $time);
    end
    total++;
    if (readdata !== exp_rd) begin
      bad++;
      $display("[TB] FAIL readdata[%0d]: got %h expected %h at %0t", address, readdata, exp_rd, $time);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    chipselect = 0; write_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
    end
    reset_n = 1;
    address = 2'd0;
    tick();
    total++;
    if (readdata !== 32'd12500000) begin
      bad++;
      $display("[TB] FAIL reset_on_time: got %0d expected 12500000", readdata);
    end
  endtask

  task automatic test_blink_pattern();
    logic [11:0] pat = 12'b111001110011;
    wr(2'd0, 32'd3);
    wr(2'd1, 32'd2);
    address = 2'd3;
    alarm_in = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (led_out !== pat[11-i]) begin
        bad++;
        $display("[TB] FAIL pattern_%0d: got %b expected %b", i, led_out, pat[11-i]);
      end
    end
    alarm_in = 0;
    tick();
    total++;
    if (led_out !== 1'b0 || readdata[31:16] !== 16'd3) begin
      bad++;
      $display("[TB] FAIL pattern_end: got led=%b cnt=%0d expected led=0 cnt=3", led_out, readdata[31:16]);
    end
  endtask

  task automatic test_early_drop();
    address = 2'd3;
    alarm_in = 1;
    tick();
    tick();
    alarm_in = 0;
    tick();
    total++;
    if (led_out !== 1'b0 || readdata[1:0] !== 2'b00) begin
      bad++;
      $display("[TB] FAIL early_drop: got led=%b status=%b expected led=0 status=00", led_out, readdata[1:0]);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_zero_on();
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd1);
    alarm_in = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (led_out !== ((i % 2) == 0)) begin
        bad++;
        $display("[TB] FAIL zero_on_%0d: got %b expected %b", i, led_out, (i % 2) == 0);
      end
    end
    alarm_in = 0;
    tick();
  endtask

  task automatic test_invert_force();
    alarm_in = 0;
    wr(2'd2, 32'd2);
    tick();
    total++;
    if (led_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL invert_idle: got %b expected 1", led_out);
    end
    wr(2'd2, 32'd1);
    alarm_in = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (led_out !== 1'b1) begin
        bad++;
        $display("[TB] FAIL force_on_%0d: got %b expected 1", i, led_out);
      end
    end
    alarm_in = 0;
    tick();
    wr(2'd2, 32'd0);
  endtask

  task automatic test_write_during_on();
    logic [12:0] pat = 13'b1110011111001;
    wr(2'd0, 32'd3);
    wr(2'd1, 32'd2);
    alarm_in = 1;
    for (int i = 0; i < 13; i++) begin
      if (i == 1) wr(2'd0, 32'd5);
      else tick();
      total++;
      if (led_out !== pat[12-i]) begin
        bad++;
        $display("[TB] FAIL retime_%0d: got %b expected %b", i, led_out, pat[12-i]);
      end
    end
    alarm_in = 0;
    tick();
  endtask

  task automatic test_saturation();
    alarm_in = 0;
    address = 2'd3;
    tick();
    force dut.blink_cnt = 16'hFFFE;
    m_blinks = 16'hFFFE;
    tick();
    release dut.blink_cnt;
    tick();
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd1);
    address = 2'd3;
    alarm_in = 1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (readdata[31:16] !== 16'hFFFF) begin
      bad++;
      $display("[TB] FAIL saturate: got %h expected ffff", readdata[31:16]);
    end
    tick();
    wr(2'd3, 32'd1);
    total++;
    if (readdata[31:16] !== 16'h0000 || led_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clear_wins: got cnt=%h led=%b expected cnt=0000 led=1", readdata[31:16], led_out);
    end
    alarm_in = 0;
    tick();
  endtask

  task automatic test_reset_mid_on();
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd2);
    alarm_in = 1;
    tick();
    tick();
    reset_n = 0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      total++;
      if (led_out !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_mid_led: got %b expected 0", led_out);
      end
    end
    reset_n = 1;
    address = 2'd3;
    tick();
    total++;
    if (led_out !== 1'b1 || readdata !== 32'h0001_0003) begin
      bad++;
      $display("[TB] FAIL restart: got led=%b status=%h expected led=1 status=00010003", led_out, readdata);
    end
    alarm_in = 0;
    tick();
  endtask

  task automatic test_random();
    int sel;
    wr(2'd0, 32'd2);
    wr(2'd1, 32'd3);
    for (int i = 0; i < 400; i++) begin
      alarm_in   = ($urandom_range(0, 9) != 0);
      address    = 2'($urandom_range(0, 3));
      sel        = $urandom_range(0, 9);
      chipselect = (sel <= 2);
      write_n    = !(sel == 0 || sel == 1 || sel == 9);
      if (address < 2) writedata = ($urandom() & 32'hFF00_0000) | 32'($urandom_range(0, 4));
      else writedata = $urandom();
      tick();
    end
    chipselect = 0;
    write_n = 1;
    alarm_in = 0;
    tick();
  endtask

  // Test sequence.
  initial begin
    reset_n = 0; address = 0; chipselect = 0; write_n = 1;
    writedata = 0; alarm_in = 0;
    m_phase = 0; m_left = 0; m_on = 0; m_off = 0;
    m_force = 0; m_inv = 0; m_led = 0; m_blinks = 0;
    @(negedge clk);
    test_reset();
    test_blink_pattern();
    test_early_drop();
    test_zero_on();
    test_invert_force();
    test_write_during_on();
    test_saturation();
    test_reset_mid_on();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_led_blinker.md
ALARM_LED_BLINKER -- requirements
Module: alarm_led_blinker

Interface
REQ-001 Parameter: CNT_W, 24, width of the ON_TIME/OFF_TIME registers and the phase counter.
REQ-002 Parameter: DEF_ON, 12500000, reset value of ON_TIME in clk cycles.
REQ-003 Parameter: DEF_OFF, 12500000, reset value of OFF_TIME in clk cycles.
REQ-004 Port: clk  in  1  single system clock; all state updates on rising edge.
REQ-005 Port: reset_n  in  1  reset; synchronous and active-low.
REQ-006 Port: address  in  2  Avalon-MM slave word address.
REQ-007 Port: chipselect  in  1  slave select.
REQ-008 Port: write_n  in  1  active-low write strobe.
REQ-009 Port: writedata  in  32  write data.
REQ-010 Port: readdata  out  32  combinational read data for the current address, zero-extended.
REQ-011 Port: alarm_in  in  1  alarm request level, driven by the upstream LED PIO out_port, same clock domain.
REQ-012 Port: led_out  out  1  LED drive, 1 = lit.

Function
REQ-013 Register map SHALL be: 0 ON_TIME[CNT_W-1:0]; 1 OFF_TIME[CNT_W-1:0]; 2 CONTROL (bit0 force_on, bit1 invert); 3 STATUS (read: bit0 active, bit1 phase_on, bits[31:16] blink_cnt; write: bit0=1 clears blink_cnt).
REQ-014 A write SHALL occur on the rising edge where chipselect=1, write_n=0; only the bits defined for that address SHALL be stored, and undefined bits SHALL read 0.
REQ-015 An ON_TIME or OFF_TIME value of 0 SHALL be treated as 1.
REQ-016 The FSM SHALL have the states IDLE, ON and OFF.
REQ-017 IDLE -> ON SHALL occur at the edge where alarm_in=1; phase counter loads ON_TIME-1.
REQ-018 In ON, the counter SHALL decrement each cycle; at counter==0 the FSM goes to OFF and loads OFF_TIME-1, so ON lasts exactly ON_TIME cycles.
REQ-019 In OFF, at counter==0 the FSM SHALL go to ON (reload ON_TIME-1) if alarm_in=1, else to IDLE; OFF lasts exactly OFF_TIME cycles.
REQ-020 alarm_in=0 sampled in ON or OFF SHALL force IDLE at that edge, overriding the counter.
REQ-021 Every IDLE->ON or OFF->ON transition SHALL increment blink_cnt, saturating at 0xFFFF.
REQ-022 If a blink_cnt clear write and an increment occur on the same edge, the clear SHALL win, and blink_cnt SHALL be 0.
REQ-023 A write to ON_TIME/OFF_TIME SHALL NOT alter the running counter; the new value applies at the next phase load, including a load on the same edge as the write.
REQ-024 led_out SHALL be a registered output; led_raw = (next state == ON) OR force_on; led_out = led_raw XOR invert, so led_out changes in the same cycle as the state.
REQ-025 STATUS.active SHALL be 1 in ON or OFF; STATUS.phase_on SHALL be 1 in ON.

Reset
REQ-026 When reset_n=0 at an edge, the block SHALL go to IDLE, set counter=0, ON_TIME=DEF_ON, OFF_TIME=DEF_OFF, CONTROL=0, blink_cnt=0 and led_out=0, regardless of the current state or any write.
REQ-027 Reset mid-blink SHALL take effect at that edge; after reset_n returns to 1, a still-high alarm_in SHALL restart from IDLE->ON per REQ-017.

Verification
REQ-028 ON=3, OFF=2, alarm_in held 1 for 12 cycles -> led_out pattern 1,1,1,0,0,1,1,1,0,0,1,1, then 0 after alarm_in drops; blink_cnt=3.
REQ-029 ON=3, OFF=2, alarm_in drops in cycle 2 of ON -> led_out=0 and active=0 from the next edge; no OFF phase occurs.
REQ-030 ON_TIME write 0 with OFF=1 -> led_out alternates 1,0 every cycle while alarm_in=1.
REQ-031 invert=1, alarm_in=0 -> led_out=1; force_on=1, invert=0 -> led_out=1 in every state.
REQ-032 Write ON_TIME=5 during an ON phase of 3 -> current phase still lasts 3 cycles, and the next ON lasts 5 cycles.
REQ-033 Preload blink_cnt=0xFFFF, then another blink -> stays 0xFFFF; STATUS clear write on the same edge as an increment -> 0; reset_n=0 mid-ON -> led_out=0 and all registers at their defaults on the next cycle.
